sb_reg_file: RTL and testbench

Parametrised general-purpose register file with a built-in pending-write scoreboard for the pipelined CPU datapath. It provides two combinational read ports, one clocked write port, optional write-to-read bypass, and per-register "pending" tracking so the issue stage can detect read-after-write hazards without a separate hazard unit. It sits between decode/issue (read, issue) and writeback (write, clear) and replaces the fixed 32×32 file in the pipelined core.

---
 rtl/sb_reg_file_if.sv | 38 +++
 rtl/sb_reg_file.sv | 123 ++++++++++++
 tb/tb_sb_reg_file.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_reg_file_if.sv
// sb_reg_file_if: groups the data, scoreboard and debug signals of the
// register file into one bundle.
//   master : issue/writeback side (drives addresses, data, issue, flush)
//   slave  : the register file itself (drives read data, busy, counts)
// All inputs are sampled on the rising edge of the register file clock.
// Read data and busy flags are combinational, with no valid/ready
// handshake. A write happens on every edge where we=1, and an issue
// happens on every edge where iss_en=1.
interface sb_reg_file_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          we;
    logic [AW-1:0] rw;
    logic [DW-1:0] din;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          iss_en;
    logic [AW-1:0] iss_rd;
    logic          flush;
    logic          busy_a;
    logic          busy_b;
    logic [AW:0]   pend_cnt;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    modport master (
        output we, rw, din, ra, rb, iss_en, iss_rd, flush, dbg_addr,
        input  a, b, busy_a, busy_b, pend_cnt, dbg_data
    );

    modport slave (
        input  we, rw, din, ra, rb, iss_en, iss_rd, flush, dbg_addr,
        output a, b, busy_a, busy_b, pend_cnt, dbg_data
    );
endinterface

// File: rtl/sb_reg_file.sv
// sb_reg_file: register file with 2^AW entries of DW bits. It has two
// combinational read ports, one clocked write port and optional write-to-read
// bypass. Each register also has a pending bit, so the issue stage can see
// read-after-write hazards.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : sb_reg_file_if.slave
//                write     : we, rw, din
//                read      : ra, rb -> a, b
//                scoreboard: iss_en, iss_rd, flush -> busy_a, busy_b, pend_cnt
//                debug     : dbg_addr -> dbg_data (registered, pre-write value)
module sb_reg_file #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    sb_reg_file_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic [DW-1:0]    dbg_q;

    logic wr_ok;
    logic iss_ok;
    logic set_t;
    logic clr_t;

    // r0 is hard-wired to zero when ZERO_R0 is set. Writes to it and issues
    // for it are dropped before they reach the state.
    assign wr_ok  = bus.we && !(ZERO_R0 && (bus.rw == '0));
    assign iss_ok = bus.iss_en && !bus.flush && !(ZERO_R0 && (bus.iss_rd == '0));

    // Pending vector: a new issue wins over a writeback to the same register,
    // because the issue belongs to a younger producer.
    always_comb begin
        pend_d = pend_q;
        if (bus.flush) begin
            pend_d = '0;
        end else begin
            if (bus.we) pend_d[bus.rw] = 1'b0;
            if (iss_ok) pend_d[bus.iss_rd] = 1'b1;
        end
    end

    // The count follows real bit transitions only. A set of a bit that is
    // already set does not change it. A clear that loses to a same-register
    // set does not change it either.
    assign set_t = iss_ok && !pend_q[bus.iss_rd];
    assign clr_t = bus.we && pend_q[bus.rw] && !(iss_ok && (bus.iss_rd == bus.rw));

    always_comb begin
        cnt_d = cnt_q;
        if (bus.flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{AW{1'b0}}, set_t} - {{AW{1'b0}}, clr_t};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            dbg_q  <= '0;
        end else begin
            if (wr_ok) regs[bus.rw] <= bus.din;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            dbg_q  <= regs[bus.dbg_addr];
        end
    end

    // Read ports
    always_comb begin
        bus.a = regs[bus.ra];
        if (ZERO_R0 && (bus.ra == '0)) begin
            bus.a = '0;
        end else if (BYPASS && wr_ok && (bus.rw == bus.ra)) begin
            bus.a = bus.din;
        end
    end

    always_comb begin
        bus.b = regs[bus.rb];
        if (ZERO_R0 && (bus.rb == '0)) begin
            bus.b = '0;
        end else if (BYPASS && wr_ok && (bus.rw == bus.rb)) begin
            bus.b = bus.din;
        end
    end

    // A same-cycle writeback resolves the hazard only when the write data is
    // forwarded, so this override applies only with bypass enabled.
    always_comb begin
        bus.busy_a = pend_q[bus.ra];
        if (ZERO_R0 && (bus.ra == '0)) begin
            bus.busy_a = 1'b0;
        end else if (BYPASS && bus.we && (bus.rw == bus.ra)) begin
            bus.busy_a = 1'b0;
        end
    end

    always_comb begin
        bus.busy_b = pend_q[bus.rb];
        if (ZERO_R0 && (bus.rb == '0)) begin
            bus.busy_b = 1'b0;
        end else if (BYPASS && bus.we && (bus.rw == bus.rb)) begin
            bus.busy_b = 1'b0;
        end
    end

    assign bus.pend_cnt = cnt_q;
    assign bus.dbg_data = dbg_q;
endmodule

// File: tb/tb_sb_reg_file.sv
module tb_sb_reg_file;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic        t_we = 1'b0;
    logic [4:0]  t_rw = '0;
    logic [31:0] t_din = '0;
    logic [4:0]  t_ra = '0;
    logic [4:0]  t_rb = '0;
    logic        t_iss = 1'b0;
    logic [4:0]  t_rd = '0;
    logic        t_flush = 1'b0;
    logic [4:0]  t_dbg = '0;

    // bus1: BYPASS=1, ZERO_R0=1 ; bus0: BYPASS=0, ZERO_R0=0
    sb_reg_file_if #(.DW(32), .AW(5)) bus1 ();
    sb_reg_file_if #(.DW(32), .AW(5)) bus0 ();

    assign bus1.we = t_we;     assign bus0.we = t_we;
    assign bus1.rw = t_rw;     assign bus0.rw = t_rw;
    assign bus1.din = t_din;   assign bus0.din = t_din;
    assign bus1.ra = t_ra;     assign bus0.ra = t_ra;
    assign bus1.rb = t_rb;     assign bus0.rb = t_rb;
    assign bus1.iss_en = t_iss; assign bus0.iss_en = t_iss;
    assign bus1.iss_rd = t_rd; assign bus0.iss_rd = t_rd;
    assign bus1.flush = t_flush; assign bus0.flush = t_flush;
    assign bus1.dbg_addr = t_dbg; assign bus0.dbg_addr = t_dbg;

    sb_reg_file #(.DW(32), .AW(5), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    sb_reg_file #(.DW(32), .AW(5), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Index 0 models dut1 (bypass, zero r0), index 1 models dut0.
    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    function automatic bit cfg_z(input int c);
        return c == 0;
    endfunction

    function automatic logic [31:0] m_read(input int c, input logic [4:0] addr);
        if (cfg_z(c) && addr == 0) return 32'h0;
        if (c == 0 && t_we && t_rw == addr) return t_din;
        return m_regs[c][addr];
    endfunction

    function automatic logic m_busy(input int c, input logic [4:0] addr);
        if (cfg_z(c) && addr == 0) return 1'b0;
        if (c == 0 && t_we && t_rw == addr) return 1'b0;
        return m_pend[c][addr];
    endfunction

    function automatic int m_count(input int c);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[c][i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) begin
                m_regs[c][i] = '0;
                m_pend[c][i] = 1'b0;
            end
        exp_q0.delete();
        exp_q1.delete();
        exp_q0.push_back(32'h0);
        exp_q1.push_back(32'h0);
    endtask

    task automatic m_clock();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) exp_q0.push_back(m_regs[c][t_dbg]);
            else        exp_q1.push_back(m_regs[c][t_dbg]);
            if (t_we && !(cfg_z(c) && t_rw == 0)) m_regs[c][t_rw] = t_din;
            if (t_flush) begin
                for (int i = 0; i < 32; i++) m_pend[c][i] = 1'b0;
            end else begin
                if (t_we) m_pend[c][t_rw] = 1'b0;
                if (t_iss && !(cfg_z(c) && t_rd == 0)) m_pend[c][t_rd] = 1'b1;
            end
        end
    endtask

    task automatic m_check();
        logic [31:0] ed;
        ed = exp_q0.pop_front();
        chk("m1_a", bus1.a, m_read(0, t_ra));
        chk("m1_b", bus1.b, m_read(0, t_rb));
        chk("m1_busy_a", 32'(bus1.busy_a), 32'(m_busy(0, t_ra)));
        chk("m1_busy_b", 32'(bus1.busy_b), 32'(m_busy(0, t_rb)));
        chk("m1_cnt", 32'(bus1.pend_cnt), 32'(m_count(0)));
        chk("m1_dbg", bus1.dbg_data, ed);
        ed = exp_q1.pop_front();
        chk("m0_a", bus0.a, m_read(1, t_ra));
        chk("m0_b", bus0.b, m_read(1, t_rb));
        chk("m0_busy_a", 32'(bus0.busy_a), 32'(m_busy(1, t_ra)));
        chk("m0_busy_b", 32'(bus0.busy_b), 32'(m_busy(1, t_rb)));
        chk("m0_cnt", 32'(bus0.pend_cnt), 32'(m_count(1)));
        chk("m0_dbg", bus0.dbg_data, ed);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [4:0] rw, input logic [31:0] din,
                         input logic [4:0] ra, input logic [4:0] rb, input logic iss,
                         input logic [4:0] rd, input logic flush);
        t_we = we; t_rw = rw; t_din = din; t_ra = ra; t_rb = rb;
        t_iss = iss; t_rd = rd; t_flush = flush; t_dbg = ra;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        drive(1'b0, 5'd0, 32'h0, ra, rb, 1'b0, 5'd0, 1'b0);
    endtask

    // Called just after a rising edge with inputs driven: model check at the
    // falling edge, then a clock edge and model update.
    task automatic step();
        @(negedge clk);
        m_check();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] din;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        iss;
        logic [4:0]  rd;
        logic        flush;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eba;
        logic        ebb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Expected outputs of dut1 (bypass, zero r0), before each edge.
        tbl[0]  = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
        tbl[3]  = '{1'b1, 5'd7, 32'h55,       5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'h55,       32'h55,       1'b0, 1'b0, 6'd1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 1'b0, 5'd0, 1'b0, 32'h55,       32'h12345678, 1'b0, 1'b0, 6'd0};
        tbl[5]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0,        32'h12345678, 1'b0, 1'b0, 6'd0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        tbl[8]  = '{1'b1, 5'd9, 32'h99,       5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 32'h99,       32'h99,       1'b0, 1'b0, 6'd1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 32'h99,       32'h99,       1'b1, 1'b1, 6'd1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 32'h99,       32'h0,        1'b1, 1'b0, 6'd1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 32'h99,       32'h99,       1'b1, 1'b1, 6'd1};
        tbl[12] = '{1'b1, 5'd2, 32'h22,       5'd2, 5'd9, 1'b1, 5'd2, 1'b1, 32'h22,       32'h99,       1'b0, 1'b1, 6'd1};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd9, 1'b0, 5'd0, 1'b0, 32'h22,       32'h99,       1'b0, 1'b0, 6'd0};

        // ---- reset state ----
        idle(5'd3, 5'd7);
        m_reset();
        #3;
        chk("rst_a", bus1.a, 32'h0);
        chk("rst_busy_a", 32'(bus1.busy_a), 32'h0);
        chk("rst_cnt", 32'(bus1.pend_cnt), 32'h0);
        chk("rst_dbg", bus0.dbg_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].we, tbl[i].rw, tbl[i].din, tbl[i].ra, tbl[i].rb,
                  tbl[i].iss, tbl[i].rd, tbl[i].flush);
            #2;
            chk($sformatf("tbl%0d_a", i), bus1.a, tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), bus1.b, tbl[i].eb);
            chk($sformatf("tbl%0d_busy_a", i), 32'(bus1.busy_a), 32'(tbl[i].eba));
            chk($sformatf("tbl%0d_busy_b", i), 32'(bus1.busy_b), 32'(tbl[i].ebb));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus1.pend_cnt), 32'(tbl[i].ecnt));
            step();
        end

        // ---- no bypass: old value this cycle, new value next cycle ----
        drive(1'b1, 5'd4, 32'h0000ABCD, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0);
        #2;
        chk("nobyp_a_old", bus0.a, 32'h0);
        chk("nobyp_b_old", bus0.b, 32'h0);
        chk("byp_a_new", bus1.a, 32'h0000ABCD);
        step();
        idle(5'd4, 5'd4);
        #2;
        chk("nobyp_a_new", bus0.a, 32'h0000ABCD);
        chk("nobyp_b_new", bus0.b, 32'h0000ABCD);
        step();

        // ---- fill the scoreboard, reissue, then flush against an issue ----
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(r), 5'd0, 1'b1, 5'(r), 1'b0);
            step();
        end
        idle(5'd5, 5'd6);
        #2;
        chk("fill_cnt1", 32'(bus1.pend_cnt), 32'd31);
        chk("fill_cnt0", 32'(bus0.pend_cnt), 32'd31);
        chk("fill_busy", 32'(bus1.busy_a), 32'h1);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0);
        step();
        idle(5'd5, 5'd6);
        #2;
        chk("reissue_cnt", 32'(bus1.pend_cnt), 32'd31);
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1);
        step();
        idle(5'd2, 5'd3);
        #2;
        chk("flush_cnt1", 32'(bus1.pend_cnt), 32'd0);
        chk("flush_cnt0", 32'(bus0.pend_cnt), 32'd0);
        for (int r = 0; r < 32; r++) begin
            t_ra = 5'(r);
            t_rb = 5'(31 - r);
            #0.1;
            if (bus1.busy_a || bus1.busy_b || bus0.busy_a || bus0.busy_b)
                chk($sformatf("flush_busy_r%0d", r), 32'h1, 32'h0);
            else
                chk($sformatf("flush_busy_r%0d", r), 32'h0, 32'h0);
        end
        idle(5'd0, 5'd0);
        step();

        // ---- asynchronous reset in mid-cycle, during a write ----
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
        step();
        drive(1'b1, 5'd5, 32'h12121212, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1 idle(5'd5, 5'd5);
        #0.5;
        chk("arst_a1", bus1.a, 32'h0);
        chk("arst_busy1", 32'(bus1.busy_a), 32'h0);
        chk("arst_cnt1", 32'(bus1.pend_cnt), 32'h0);
        chk("arst_a0", bus0.a, 32'h0);
        chk("arst_cnt0", 32'(bus0.pend_cnt), 32'h0);
        chk("arst_dbg0", bus0.dbg_data, 32'h0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5'd5, 5'd5);
        step();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            t_we    = 1'($urandom_range(0, 1));
            t_rw    = rnd_addr();
            t_din   = $urandom;
            t_ra    = rnd_addr();
            t_rb    = rnd_addr();
            t_iss   = ($urandom_range(0, 3) != 0);
            t_rd    = rnd_addr();
            t_flush = ($urandom_range(0, 19) == 0);
            t_dbg   = 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
